// File: rtl/watch_pkg.sv
// Shared constants, key map and field-step helper for the watch core.
`timescale 1ns/1ps
package watch_pkg;

    localparam int unsigned SEC_MAX  = 59;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned HOUR_12  = 12;
    localparam int unsigned BCD_W    = 4;

    localparam int unsigned K_HOUR_UP = 0;
    localparam int unsigned K_HOUR_DN = 1;
    localparam int unsigned K_MIN_UP  = 2;
    localparam int unsigned K_MIN_DN  = 3;
    localparam int unsigned K_SEC_UP  = 4;
    localparam int unsigned K_SEC_DN  = 5;
    localparam int unsigned K_MODE    = 6;
    localparam int unsigned K_AL_SEL  = 7;

    // One adjust step with wrap in both directions; up+dn together cancel.
    function automatic logic [5:0] step_field(input logic [5:0] val, input logic [5:0] max,
                                              input logic up, input logic dn);
        logic [5:0] res;
        res = val;
        if (up && !dn) begin
            res = (val == max) ? 6'd0 : val + 6'd1;
        end else if (dn && !up) begin
            res = (val == 6'd0) ? max : val - 6'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/watch_bcd_split.sv
// Splits a 0..99 binary value into tens and ones BCD digits.
`timescale 1ns/1ps
module watch_bcd_split
    import watch_pkg::*;
(
    input  logic [6:0]       bin,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones
);

    assign tens = BCD_W'(bin / 7'd10);
    assign ones = BCD_W'(bin % 7'd10);

endmodule

// File: rtl/watch_core_p.sv
// Digital watch: tick divider, HH:MM:SS time with key adjust, alarm, 12/24 h display.
`timescale 1ns/1ps
module watch_core_p
    import watch_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 100000,
    parameter bit          H24_DEFAULT = 1'b1,
    parameter int unsigned ALARM_LEN   = 60
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [7:0] KEY,
    input  logic       ALARM_EN,
    output logic [3:0] H10,
    output logic [3:0] H1,
    output logic [3:0] M10,
    output logic [3:0] M1,
    output logic [3:0] S10,
    output logic [3:0] S1,
    output logic       PM,
    output logic       ALARM,
    output logic       SEC_TICK
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0] div_q;
    logic [4:0]       hour_q, hour_d, al_hour_q, al_hour_d;
    logic [5:0]       min_q, min_d, sec_q, sec_d, al_min_q, al_min_d;
    logic             h24_q, key6_q;
    logic             alarm_q, alarm_d;
    logic [7:0]       alarm_cnt_q, alarm_cnt_d;

    logic             sec_c, min_c, time_adj, normal_adv, match;
    logic [4:0]       adv_hour;
    logic [5:0]       adv_min, adv_sec;

    logic [4:0]       disp_hour, show_hour;
    logic [5:0]       show_min, show_sec;
    logic             pm;

    assign SEC_TICK = RESETN && (div_q == DIV_W'(TICK_DIV - 1));

    always_comb begin
        sec_c    = (sec_q == 6'(SEC_MAX));
        min_c    = sec_c && (min_q == 6'(MIN_MAX));
        adv_sec  = sec_c ? 6'd0 : sec_q + 6'd1;
        adv_min  = sec_c ? ((min_q == 6'(MIN_MAX)) ? 6'd0 : min_q + 6'd1) : min_q;
        adv_hour = min_c ? ((hour_q == 5'(HOUR_MAX)) ? 5'd0 : hour_q + 5'd1) : hour_q;

        // In alarm-edit the keys steer the alarm registers and time runs freely.
        time_adj   = !KEY[K_AL_SEL] && (|KEY[5:0]);
        normal_adv = SEC_TICK && !time_adj;

        hour_d    = hour_q;
        min_d     = min_q;
        sec_d     = sec_q;
        al_hour_d = al_hour_q;
        al_min_d  = al_min_q;

        if (normal_adv) begin
            hour_d = adv_hour;
            min_d  = adv_min;
            sec_d  = adv_sec;
        end else if (SEC_TICK) begin
            hour_d = 5'(step_field({1'b0, hour_q}, 6'(HOUR_MAX),
                                   KEY[K_HOUR_UP], KEY[K_HOUR_DN]));
            min_d  = step_field(min_q, 6'(MIN_MAX), KEY[K_MIN_UP], KEY[K_MIN_DN]);
            sec_d  = step_field(sec_q, 6'(SEC_MAX), KEY[K_SEC_UP], KEY[K_SEC_DN]);
        end

        if (SEC_TICK && KEY[K_AL_SEL]) begin
            al_hour_d = 5'(step_field({1'b0, al_hour_q}, 6'(HOUR_MAX),
                                      KEY[K_HOUR_UP], KEY[K_HOUR_DN]));
            al_min_d  = step_field(al_min_q, 6'(MIN_MAX), KEY[K_MIN_UP], KEY[K_MIN_DN]);
        end

        match = ALARM_EN && normal_adv && (adv_hour == al_hour_q) && (adv_min == al_min_q) &&
                (adv_sec == 6'd0);

        alarm_d     = alarm_q;
        alarm_cnt_d = alarm_cnt_q;
        if (!ALARM_EN) begin
            alarm_d     = 1'b0;
            alarm_cnt_d = 8'd0;
        end else if (match) begin
            alarm_d     = 1'b1;
            alarm_cnt_d = 8'd0;
        end else if (alarm_q && SEC_TICK) begin
            if (alarm_cnt_q == 8'(ALARM_LEN - 1)) begin
                alarm_d     = 1'b0;
                alarm_cnt_d = 8'd0;
            end else begin
                alarm_cnt_d = alarm_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            div_q       <= '0;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            al_hour_q   <= '0;
            al_min_q    <= '0;
            h24_q       <= H24_DEFAULT;
            key6_q      <= 1'b0;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
        end else begin
            div_q       <= SEC_TICK ? '0 : div_q + 1'b1;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            al_hour_q   <= al_hour_d;
            al_min_q    <= al_min_d;
            key6_q      <= KEY[K_MODE];
            if (KEY[K_MODE] && !key6_q) begin
                h24_q <= ~h24_q;
            end
            alarm_q     <= alarm_d;
            alarm_cnt_q <= alarm_cnt_d;
        end
    end

    always_comb begin
        disp_hour = KEY[K_AL_SEL] ? al_hour_q : hour_q;
        show_min  = KEY[K_AL_SEL] ? al_min_q : min_q;
        show_sec  = KEY[K_AL_SEL] ? 6'd0 : sec_q;
        show_hour = disp_hour;
        pm        = 1'b0;
        if (!h24_q) begin
            pm = (disp_hour >= 5'(HOUR_12));
            if (disp_hour == 5'd0) begin
                show_hour = 5'(HOUR_12);
            end else if (disp_hour > 5'(HOUR_12)) begin
                show_hour = disp_hour - 5'(HOUR_12);
            end
        end
    end

    assign PM    = pm;
    assign ALARM = alarm_q;

    watch_bcd_split u_bcd_hour (
        .bin  ({2'b00, show_hour}),
        .tens (H10),
        .ones (H1)
    );

    watch_bcd_split u_bcd_min (
        .bin  ({1'b0, show_min}),
        .tens (M10),
        .ones (M1)
    );

    watch_bcd_split u_bcd_sec (
        .bin  ({1'b0, show_sec}),
        .tens (S10),
        .ones (S1)
    );

endmodule

// File: tb/tb_watch_core_p.sv
// Directed scoreboard bench for watch_core_p with TICK_DIV=4, ALARM_LEN=3.
`timescale 1ns/1ps
module tb_watch_core_p;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic [7:0] KEY;
    logic       ALARM_EN;
    logic [3:0] H10, H1, M10, M1, S10, S1;
    logic       PM, ALARM, SEC_TICK;

    int unsigned total  = 0;
    int unsigned passed = 0;
    logic [31:0] exp_q[$];

    watch_core_p #(
        .TICK_DIV    (4),
        .H24_DEFAULT (1'b1),
        .ALARM_LEN   (3)
    ) dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .KEY      (KEY),
        .ALARM_EN (ALARM_EN),
        .H10      (H10),
        .H1       (H1),
        .M10      (M10),
        .M1       (M1),
        .S10      (S10),
        .S1       (S1),
        .PM       (PM),
        .ALARM    (ALARM),
        .SEC_TICK (SEC_TICK)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] disp(input int h, input int m, input int s, input bit pm);
        return {7'd0, 4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                pm};
    endfunction

    function automatic logic [31:0] obs_disp();
        return {7'd0, H10, H1, M10, M1, S10, S1, PM};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        exp = (exp_q.size() == 0) ? 32'hdead_beef : exp_q.pop_front();
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Returns #1 after the rising edge that consumed a SEC_TICK cycle.
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!SEC_TICK && n < 20);
        if (!SEC_TICK) begin
            exp_q.push_back(32'd1);
            check("tick_timeout", 32'd0);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic hold_keys(input logic [7:0] k, input int n);
        KEY = k;
        repeat (n) wait_tick();
        KEY = 8'h00;
    endtask

    task automatic pulse_mode();
        KEY[6] = 1'b1;
        @(posedge CLK);
        #1;
        KEY[6] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RESETN = 1'b0;
        @(posedge CLK);
        #1;
        RESETN = 1'b1;
    endtask

    initial begin
        int highs;
        RESETN   = 1'b0;
        KEY      = 8'h00;
        ALARM_EN = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        exp_q.push_back(32'd0);
        check("tick_in_reset", {31'd0, SEC_TICK});
        @(posedge CLK);
        #1;
        RESETN = 1'b1;
        exp_q.push_back(disp(0, 0, 0, 0));
        check("reset_time", obs_disp());
        exp_q.push_back(32'd0);
        check("reset_alarm", {31'd0, ALARM});

        // One tick every 4 cycles
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (SEC_TICK) highs++;
        end
        exp_q.push_back(32'd2);
        check("tick_period", 32'(highs));

        pulse_reset();
        exp_q.push_back(disp(0, 0, 0, 0));
        check("reset_again", obs_disp());

        // Preset 23:59:58 via down keys, then rollover
        exp_q.push_back(disp(23, 59, 59, 0));
        hold_keys(8'b0010_1010, 1);
        check("preset_dn3", obs_disp());
        exp_q.push_back(disp(23, 59, 58, 0));
        hold_keys(8'b0010_0000, 1);
        check("preset_sec", obs_disp());
        exp_q.push_back(disp(23, 59, 59, 0));
        wait_tick();
        check("roll_1", obs_disp());
        exp_q.push_back(disp(0, 0, 0, 0));
        wait_tick();
        check("roll_2", obs_disp());

        // Down-wrap
        exp_q.push_back(disp(23, 0, 0, 0));
        hold_keys(8'b0000_0010, 1);
        check("hour_dn_wrap", obs_disp());
        exp_q.push_back(disp(23, 0, 59, 0));
        hold_keys(8'b0010_0000, 1);
        check("sec_dn_wrap", obs_disp());

        // 12 h display
        exp_q.push_back(disp(0, 0, 59, 0));
        hold_keys(8'b0000_0001, 1);
        check("hour_up_wrap", obs_disp());
        exp_q.push_back(disp(12, 0, 59, 0));
        pulse_mode();
        check("h12_midnight", obs_disp());
        exp_q.push_back(disp(1, 0, 59, 1));
        hold_keys(8'b0000_0001, 13);
        check("h12_13h", obs_disp());
        exp_q.push_back(disp(13, 0, 59, 0));
        pulse_mode();
        check("h24_back", obs_disp());

        // Conflict at 00:10:30
        hold_keys(8'b0000_0001, 11);
        hold_keys(8'b0000_0100, 10);
        exp_q.push_back(disp(0, 10, 30, 0));
        hold_keys(8'b0010_0000, 29);
        check("preset_001030", obs_disp());
        exp_q.push_back(disp(0, 10, 30, 0));
        hold_keys(8'b0000_1100, 1);
        check("min_conflict", obs_disp());
        exp_q.push_back(disp(0, 10, 31, 0));
        wait_tick();
        check("advance_resume", obs_disp());

        // Alarm edit: time keeps running, display shows alarm
        hold_keys(8'b1000_0100, 1);
        KEY = 8'b1000_0000;
        #1;
        exp_q.push_back(disp(0, 1, 0, 0));
        check("al_edit_disp", obs_disp());
        KEY = 8'h00;
        #1;
        exp_q.push_back(disp(0, 10, 32, 0));
        check("al_edit_time", obs_disp());

        // Alarm at 00:01:00 for 3 ticks
        hold_keys(8'b0000_1000, 10);
        exp_q.push_back(disp(0, 0, 59, 0));
        hold_keys(8'b0001_0000, 27);
        check("preset_000059", obs_disp());
        ALARM_EN = 1'b1;
        #1;
        exp_q.push_back(32'd0);
        check("alarm_idle", {31'd0, ALARM});
        wait_tick();
        exp_q.push_back(32'd1);
        check("alarm_rise", {31'd0, ALARM});
        exp_q.push_back(disp(0, 1, 0, 0));
        check("alarm_time", obs_disp());
        wait_tick();
        exp_q.push_back(32'd1);
        check("alarm_hold1", {31'd0, ALARM});
        wait_tick();
        exp_q.push_back(32'd1);
        check("alarm_hold2", {31'd0, ALARM});
        wait_tick();
        exp_q.push_back(32'd0);
        check("alarm_end", {31'd0, ALARM});

        // Reset mid-alarm, in 12 h mode
        hold_keys(8'b0000_1000, 1);
        exp_q.push_back(disp(0, 0, 59, 0));
        hold_keys(8'b0010_0000, 4);
        check("preset2", obs_disp());
        exp_q.push_back(disp(12, 0, 59, 0));
        pulse_mode();
        check("h12_pre_alarm", obs_disp());
        wait_tick();
        exp_q.push_back(32'd1);
        check("alarm2_rise", {31'd0, ALARM});
        pulse_reset();
        exp_q.push_back(32'd0);
        check("rst_alarm", {31'd0, ALARM});
        exp_q.push_back(disp(0, 0, 0, 0));
        check("rst_time_mode", obs_disp());

        // Key adjust landing on alarm time (00:00) must not fire
        hold_keys(8'b0010_0000, 1);
        exp_q.push_back(disp(0, 0, 0, 0));
        hold_keys(8'b0001_0000, 1);
        check("land_time", obs_disp());
        exp_q.push_back(32'd0);
        check("land_no_alarm", {31'd0, ALARM});
        repeat (2) wait_tick();
        exp_q.push_back(disp(0, 0, 2, 0));
        check("post_time", obs_disp());
        exp_q.push_back(32'd0);
        check("post_no_alarm", {31'd0, ALARM});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/watch_core_p.md
WATCH_CORE_P -- requirements
Module: watch_core_p

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000, meaning clock cycles per one-second tick (>=2).
REQ-002 SHALL have parameter H24_DEFAULT, default 1, meaning display mode after reset (1 = 24 h, 0 = 12 h).
REQ-003 SHALL have parameter ALARM_LEN, default 60, meaning alarm output duration in ticks (1..255).
REQ-004 SHALL have port CLK, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-005 SHALL have port RESETN, input, 1, meaning reset; one clock, reset is synchronous and active-low.
REQ-006 SHALL have port KEY, input, 8, meaning level keys: [0] hour+, [1] hour-, [2] min+, [3] min-, [4] sec+, [5] sec-, [6] 12/24 toggle, [7] alarm-edit select.
REQ-007 SHALL have port ALARM_EN, input, 1, meaning alarm arm enable.
REQ-008 SHALL have ports H10, H1, M10, M1, S10, S1, output, 4 each, meaning BCD display digits.
REQ-009 SHALL have port PM, output, 1, meaning afternoon indicator, valid in 12 h mode, 0 in 24 h mode.
REQ-010 SHALL have port ALARM, output, 1, meaning alarm active.
REQ-011 SHALL have port SEC_TICK, output, 1, meaning one-cycle pulse per tick.

Function
REQ-012 SHALL count the divider 0..TICK_DIV-1 and wrap; SEC_TICK SHALL be high for exactly the cycle when the divider equals TICK_DIV-1.
REQ-013 SHALL hold time as binary HOUR 0..23, MIN 0..59, SEC 0..59; on SEC_TICK with no adjust key active, SHALL advance SEC and carry 59->0 into MIN, and MIN 59->0 into HOUR, HOUR 23->0.
REQ-014 SHALL apply adjust keys [5:0] only on SEC_TICK cycles, one step per tick while held, with wrap in both directions: 59+1=0, 0-1=59, 23+1=0, 0-1=23.
REQ-015 SHALL not carry or borrow between fields on adjustment.
REQ-016 SHALL treat + and - of the same field pressed together as no change to that field.
REQ-017 SHALL suppress the normal advance and all carries on any SEC_TICK where any of KEY[5:0] is active.
REQ-018 SHALL, while KEY[7]=1, route KEY[3:0] to alarm registers AL_HOUR/AL_MIN instead of time; KEY[5:4] SHALL be ignored; time SHALL keep advancing normally.
REQ-019 SHALL, while KEY[7]=1, display AL_HOUR:AL_MIN on H/M digits with S10=S1=0.
REQ-020 SHALL toggle the 12/24 mode once per rising edge of KEY[6], using a registered previous-value edge detect, independent of ticks.
REQ-021 SHALL, in 12 h mode, display HOUR 0 as 12, 1..12 unchanged, 13..23 as HOUR-12, and drive PM=1 for HOUR 12..23; internal HOUR SHALL stay 0..23.
REQ-022 SHALL start alarm when ALARM_EN=1 and the tick that produces HOUR==AL_HOUR, MIN==AL_MIN, SEC==0 via normal advance occurs; ALARM SHALL rise the cycle after that tick.
REQ-023 SHALL keep ALARM high for ALARM_LEN ticks and then clear it; ALARM_EN=0 SHALL clear ALARM on the next cycle.
REQ-024 SHALL not trigger the alarm from key adjustment landing on the match time.
REQ-025 SHALL derive digits combinationally from registered values: tens = value/10, ones = value%10.

Reset
REQ-026 SHALL, on RESETN=0 at a clock edge, set divider 0, time 00:00:00, AL_HOUR 0, AL_MIN 0, mode H24_DEFAULT, ALARM 0, alarm counter 0, key-edge register 0; SEC_TICK SHALL be 0 during reset.
REQ-027 SHALL, when reset is asserted mid-alarm or mid-adjust, abandon that activity with no residual effect after release.

Structure
REQ-028 SHALL place field limits (59, 23, 12), key-bit index constants and the BCD digit width in the shared watch package.
REQ-029 SHALL use one sub-module, watch_bcd_split (7-bit binary in, two 4-bit BCD out), instantiated once per displayed field.

Verification (TICK_DIV=4, ALARM_LEN=3)
REQ-030 SHALL check rollover: preset 23:59:58, no keys, 2 ticks -> 00:00:00, H10..S1 all 0.
REQ-031 SHALL check down-wrap: time 00:00:00, KEY[1]=1 for 1 tick -> 23:00:00; KEY[5]=1 for 1 tick -> SEC 59, HOUR still 23.
REQ-032 SHALL check 12 h: pulse KEY[6], HOUR 0 -> display 12, PM=0; HOUR 13 -> display 01, PM=1.
REQ-033 SHALL check alarm: AL 00:01, ALARM_EN=1, advance from 00:00:59 -> ALARM high one cycle after tick, for 3 ticks, then low.
REQ-034 SHALL check conflict: KEY[2]=KEY[3]=1 at 00:10:30 for 1 tick -> 00:10:30 unchanged, no advance.
REQ-035 SHALL check reset mid-alarm: RESETN=0 one cycle while ALARM=1 -> ALARM 0, 00:00:00, mode H24_DEFAULT.
